gcd_arbiter: RTL

- Shares one subtractive GCD datapath among N requesters.
- Requests are arbitrated round-robin. The winner's operand pair is captured and reduced by repeated subtraction.
- The result is returned on a single response channel tagged with the requester ID, with valid/ready backpressure.
- Sits between multiple client blocks and the shared arithmetic resource, so no client needs a private GCD engine.

---
 rtl/gcd_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/gcd_arbiter.sv
// gcd_arbiter
// ---------------------------------------------------------------------------
// One subtractive GCD datapath shared by N requesters. A round-robin arbiter
// picks a requester in IDLE. Its operand pair is captured and reduced by
// repeated subtraction in COMPUTE. The result is presented in RESP on a single
// response channel that is tagged with the owner's ID.
//
// Optional feature: define GCD_ARB_CYCLE_CNT_EN to add the resp_cycles output.
// resp_cycles holds the COMPUTE-cycle count of the current result and
// saturates at 16'hFFFF.
//
// Ports
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   req[N]      per-requester request, held with stable operands until gnt
//   a_in[N*W]   operand A, requester i at [i*W +: W]
//   b_in[N*W]   operand B, same packing
//   gnt[N]      one-hot combinational accept strobe (IDLE only)
//   busy        high in every state except IDLE
//   resp_valid  result available
//   resp_ready  consumer accepts result
//   resp_id     requester that owns the result
//   resp_gcd    GCD result
//   resp_cycles (GCD_ARB_CYCLE_CNT_EN only) COMPUTE cycles for this result
//
// Response handshake: resp_valid/resp_id/resp_gcd (and resp_cycles) are
// registered. Once resp_valid is high they stay unchanged until a rising edge
// on which resp_valid && resp_ready. That edge retires the response. The
// request side uses a one-cycle gnt strobe: operands are taken on the edge
// that ends a cycle with gnt[i]=1.
// ---------------------------------------------------------------------------
module gcd_arbiter #(
  parameter int W   = 8,
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [IDW-1:0] resp_id,
  output logic [W-1:0]   resp_gcd
`ifdef GCD_ARB_CYCLE_CNT_EN
  ,
  output logic [15:0]    resp_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_t;

  // state is the FSM's observable state for checkers bound to this module.
  state_t         state;
  state_t         state_nxt;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] own_id;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [N-1:0]   win_oh;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic           done;

  // The reduction is finished once either operand is zero.
  assign done = (op_a == '0) || (op_b == '0);

  // Round-robin search in two passes. Pass one covers the set bits at or
  // above the pointer. Pass two covers the wrap-around from bit 0. Using
  // only constant loop indices keeps the selects static.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_oh    = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int i = 0; i < N; i++) begin
      if (!win_found && req[i] && (IDW'(i) >= ptr)) begin
        win_found = 1'b1;
        win_id    = IDW'(i);
        win_oh[i] = 1'b1;
        a_sel     = a_in[i*W +: W];
        b_sel     = b_in[i*W +: W];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!win_found && req[i]) begin
        win_found = 1'b1;
        win_id    = IDW'(i);
        win_oh[i] = 1'b1;
        a_sel     = a_in[i*W +: W];
        b_sel     = b_in[i*W +: W];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = COMPUTE;
      COMPUTE: if (done) state_nxt = RESP;
      RESP:    if (resp_valid && resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. gnt is also gated by reset_n so that it reads 0 while reset
  // is asserted, even when requests are pending.
  always_comb begin
    gnt  = '0;
    busy = (state != IDLE);
    if (reset_n && (state == IDLE) && win_found) gnt = win_oh;
  end

  // Datapath: operand capture, subtraction, and result registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= '0;
      own_id     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_gcd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            op_a   <= a_sel;
            op_b   <= b_sel;
            own_id <= win_id;
            ptr    <= (win_id == IDW'(N-1)) ? '0 : win_id + 1'b1;
          end
        end
        COMPUTE: begin
          if (!done) begin
            // The larger operand is always the minuend, so no underflow.
            if (op_a >= op_b) op_a <= op_a - op_b;
            else              op_b <= op_b - op_a;
          end else begin
            resp_gcd   <= (op_a == '0) ? op_b : op_a;
            resp_id    <= own_id;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef GCD_ARB_CYCLE_CNT_EN
  // cyc_cnt counts the reducing COMPUTE cycles so far. The final COMPUTE
  // cycle is added when the count is loaded into resp_cycles.
  logic [15:0] cyc_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt     <= '0;
      resp_cycles <= '0;
    end else begin
      case (state)
        IDLE: if (win_found) cyc_cnt <= '0;
        COMPUTE: begin
          if (!done) begin
            if (cyc_cnt != 16'hFFFF) cyc_cnt <= cyc_cnt + 16'd1;
          end else begin
            resp_cycles <= (cyc_cnt == 16'hFFFF) ? 16'hFFFF : cyc_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule
